// File: rtl/tq_coeff_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tq_coeff_pkg
// Description : Shared constants and FSM state type for the TQ coefficient
//               buffer write path.
// Revision    : 1.0 - initial release
// ============================================================================
package tq_coeff_pkg;

    localparam int COEFF_W       = 16;
    localparam int BEAT_COEFFS   = 8;
    localparam int BEATS_PER_ROW = 4;
    localparam int BEAT_W        = COEFF_W * BEAT_COEFFS;
    localparam int ROW_W         = 512;
    localparam int ADDR_W        = 5;
    localparam int MAX_ROWS      = 32;
    localparam int CNT_W         = 6;
    localparam int BEAT_CNT_W    = $clog2(BEATS_PER_ROW);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tq_coeff_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : tq_coeff_packer_if
// Description : Coefficient beat stream plus single-port coefficient RAM
//               write port, as seen by the packer (slave) and its peers.
// Revision    : 1.0 - initial release
// ============================================================================
interface tq_coeff_packer_if;
    import tq_coeff_pkg::*;

    logic              coeff_valid_i;
    logic [BEAT_W-1:0] coeff_data_i;
    logic              coeff_ready_o;
    logic              cen_o;
    logic              oen_o;
    logic              wen_o;
    logic [ADDR_W-1:0] addr_o;
    logic [ROW_W-1:0]  data_o;

    modport slave (
        input  coeff_valid_i, coeff_data_i,
        output coeff_ready_o, cen_o, oen_o, wen_o, addr_o, data_o
    );

    modport master (
        output coeff_valid_i, coeff_data_i,
        input  coeff_ready_o, cen_o, oen_o, wen_o, addr_o, data_o
    );

endinterface
`default_nettype wire

// File: rtl/tq_coeff_nz_detect.sv
`default_nettype none
// ============================================================================
// Module      : tq_coeff_nz_detect
// Description : Flags a packed coefficient row that holds any nonzero bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tq_coeff_nz_detect
    import tq_coeff_pkg::*;
(
    input  logic [ROW_W-1:0] i_row,
    output logic             o_nz
);

    assign o_nz = |i_row;

endmodule
`default_nettype wire

// File: rtl/tq_coeff_packer.sv
`default_nettype none
// ============================================================================
// Module      : tq_coeff_packer
// Description : Packs 128-bit coefficient beats into 512-bit rows and writes
//               them to consecutive rows of the coefficient RAM.
//               TQ_COEFF_PACK_NZ_EN adds the per-row nonzero map nz_map_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tq_coeff_packer
    import tq_coeff_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [CNT_W-1:0] row_num_i,
    tq_coeff_packer_if.slave bus,
    output logic             busy_o,
    output logic             done_o
`ifdef TQ_COEFF_PACK_NZ_EN
    ,
    output logic [MAX_ROWS-1:0] nz_map_o
`endif
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_row_total;
    logic [CNT_W-1:0]        r_row_cnt;
    logic [CNT_W-1:0]        w_row_sat;
    logic [BEAT_CNT_W-1:0]   r_beat_cnt;
    logic [ROW_W-BEAT_W-1:0] r_row_buf;
    logic                    r_ready;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_cen;
    logic                    r_wen;
    logic [ADDR_W-1:0]       r_addr;
    logic [ROW_W-1:0]        r_data;
    logic                    w_start;
    logic                    w_accept;
    logic                    w_last_beat;
    logic                    w_last_row;

    assign w_start     = (r_state == IDLE) && start_i;
    assign w_accept    = (r_state == FILL) && bus.coeff_valid_i;
    assign w_last_beat = (r_beat_cnt == BEAT_CNT_W'(BEATS_PER_ROW - 1));
    assign w_last_row  = ((r_row_cnt + CNT_W'(1)) == r_row_total);
    assign w_row_sat   = (row_num_i > CNT_W'(MAX_ROWS)) ? CNT_W'(MAX_ROWS) : row_num_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_nxt = (row_num_i == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (w_accept && w_last_beat) begin
                    w_state_nxt = WRITE;
                end
            end
            WRITE:   w_state_nxt = w_last_row ? DONE : FILL;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs are decoded from the next state so they line up with r_state
    // while still coming straight out of flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_total <= '0;
            r_row_cnt   <= '0;
            r_beat_cnt  <= '0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cen       <= 1'b1;
            r_wen       <= 1'b1;
            r_addr      <= '0;
            r_data      <= '0;
        end else begin
            if (w_start) begin
                r_row_total <= w_row_sat;
                r_row_cnt   <= '0;
                r_beat_cnt  <= '0;
            end
            if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + BEAT_CNT_W'(1);
                for (int k = 0; k < BEATS_PER_ROW - 1; k++) begin
                    if (r_beat_cnt == BEAT_CNT_W'(k)) begin
                        r_row_buf[k*BEAT_W +: BEAT_W] <= bus.coeff_data_i;
                    end
                end
                if (w_last_beat) begin
                    r_data <= {bus.coeff_data_i, r_row_buf};
                    r_addr <= r_row_cnt[ADDR_W-1:0];
                end
            end
            if (r_state == WRITE) begin
                r_row_cnt <= r_row_cnt + CNT_W'(1);
            end
            r_ready <= (w_state_nxt == FILL);
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= (w_state_nxt == DONE);
            r_cen   <= (w_state_nxt != WRITE);
            r_wen   <= (w_state_nxt != WRITE);
        end
    end

    assign bus.coeff_ready_o = r_ready;
    assign bus.cen_o         = r_cen;
    assign bus.oen_o         = 1'b1;
    assign bus.wen_o         = r_wen;
    assign bus.addr_o        = r_addr;
    assign bus.data_o        = r_data;
    assign busy_o            = r_busy;
    assign done_o            = r_done;

`ifdef TQ_COEFF_PACK_NZ_EN
    logic                w_row_nz;
    logic [MAX_ROWS-1:0] r_nz_map;

    tq_coeff_nz_detect u_nz_detect (
        .i_row (r_data),
        .o_nz  (w_row_nz)
    );

    // r_data holds the row being written for the whole WRITE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nz_map <= '0;
        end else if (w_start) begin
            r_nz_map <= '0;
        end else if (r_state == WRITE) begin
            r_nz_map[r_row_cnt[ADDR_W-1:0]] <= w_row_nz;
        end
    end

    assign nz_map_o = r_nz_map;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tq_coeff_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tq_coeff_packer
// Description : Self-checking bench for tq_coeff_packer against a row-level
//               reference model built from the stimulus beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tq_coeff_packer;
    import tq_coeff_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_i = 1'b0;
    logic [CNT_W-1:0] row_num_i = '0;
    logic             busy_o;
    logic             done_o;
`ifdef TQ_COEFF_PACK_NZ_EN
    logic [MAX_ROWS-1:0] nz_map_o;
`endif

    tq_coeff_packer_if bus ();

    tq_coeff_packer dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .row_num_i (row_num_i),
        .bus       (bus),
        .busy_o    (busy_o),
        .done_o    (done_o)
`ifdef TQ_COEFF_PACK_NZ_EN
        ,
        .nz_map_o  (nz_map_o)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cnt = 0;

    logic [ADDR_W-1:0] wa_q[$];
    logic [ROW_W-1:0]  wd_q[$];
    int                done_q[$];
    int                rdy_q[$];
    logic [31:0]       nzd_q[$];
    logic [BEAT_W-1:0] stim[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: logs accepted beats, RAM writes, done pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.coeff_valid_i && bus.coeff_ready_o) acc_cnt <= acc_cnt + 1;
            if (!bus.cen_o && !bus.wen_o) begin
                wa_q.push_back(bus.addr_o);
                wd_q.push_back(bus.data_o);
            end
            if (bus.coeff_ready_o) rdy_q.push_back(cyc);
            if (done_o) begin
                done_q.push_back(cyc);
`ifdef TQ_COEFF_PACK_NZ_EN
                nzd_q.push_back(nz_map_o);
`else
                nzd_q.push_back(32'h0);
`endif
            end
        end
    end

    task automatic chk_w(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [BEAT_W-1:0] rnd_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // mode 0: random, 1: counting beats 1,2,3..., 2: row 1 all zero
    task automatic make_stim(input int rows, input int mode);
        stim.delete();
        for (int k = 0; k < 4 * rows; k++) begin
            if (mode == 1)                      stim.push_back(BEAT_W'(k + 1));
            else if (mode == 2 && k / 4 == 1)   stim.push_back('0);
            else                                stim.push_back(rnd_beat() | BEAT_W'(1));
        end
    endtask

    function automatic logic [ROW_W-1:0] exp_row(input int r);
        return {stim[4*r+3], stim[4*r+2], stim[4*r+1], stim[4*r]};
    endfunction

    task automatic chk_idle(input string tag);
        chk_i({tag, "_busy"},  int'(busy_o), 0);
        chk_i({tag, "_ready"}, int'(bus.coeff_ready_o), 0);
        chk_i({tag, "_cen"},   int'(bus.cen_o), 1);
        chk_i({tag, "_wen"},   int'(bus.wen_o), 1);
        chk_i({tag, "_oen"},   int'(bus.oen_o), 1);
    endtask

    // vmode 0: valid always, 1: valid toggles, 2: random valid
    task automatic run_block(input string tag, input int rows, input int vmode,
                             input bit noisy, input bit poke);
        int wa0, dq0, rq0, acc0, idx, start_cyc, n_exp, n_wr, bound, v;
        bit poked;
        wa0 = wa_q.size(); dq0 = done_q.size(); rq0 = rdy_q.size(); acc0 = acc_cnt;
        idx = 0; poked = 0;
        n_exp = (rows > MAX_ROWS) ? MAX_ROWS : rows;
        bound = 20 + 12 * n_exp;
        @(posedge clk); #1;
        start_i   = 1'b1;
        row_num_i = CNT_W'(rows);
        start_cyc = cyc;
        for (int c = 0; c < bound; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                start_i = noisy && (wa_q.size() == wa0);
                if (noisy) row_num_i = 6'd7;
                if (poke && !poked && n_exp > 0 && wa_q.size() - wa0 == n_exp) begin
                    start_i = 1'b1;
                    poked   = 1'b1;
                end
                if (done_q.size() > dq0) break;
            end
            v = (vmode == 0) ? 1 : (vmode == 1) ? int'(c % 2 == 0) : int'($urandom_range(0, 1));
            if (idx >= stim.size()) v = 0;
            bus.coeff_valid_i = (v != 0);
            bus.coeff_data_i  = (v != 0) ? stim[idx] : rnd_beat();
            @(negedge clk);
            if (bus.coeff_valid_i && bus.coeff_ready_o) idx++;
        end
        start_i = 1'b0;
        bus.coeff_valid_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk_i({tag, "_done_seen"}, done_q.size() - dq0, 1);
        chk_idle({tag, "_after"});
        n_wr = wa_q.size() - wa0;
        chk_i({tag, "_nwrites"}, n_wr, n_exp);
        chk_i({tag, "_beats"}, acc_cnt - acc0, 4 * n_exp);
        for (int r = 0; r < n_wr && r < n_exp; r++) begin
            chk_i({tag, "_addr"}, int'(wa_q[wa0 + r]), r);
            chk_w({tag, "_data"}, wd_q[wa0 + r], exp_row(r));
        end
        if (vmode == 0 && done_q.size() > dq0) begin
            if (n_exp == 0) begin
                chk_i({tag, "_done_lat"}, done_q[dq0] - start_cyc, 1);
            end else if (rdy_q.size() > rq0) begin
                chk_i({tag, "_first_rdy"}, rdy_q[rq0] - start_cyc, 1);
                chk_i({tag, "_done_lat"}, done_q[dq0] - rdy_q[rq0], 5 * n_exp);
            end
        end
    endtask

    initial begin
        bus.coeff_valid_i = 1'b0;
        bus.coeff_data_i  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        chk_i("reset_done", int'(done_o), 0);
        chk_i("reset_addr", int'(bus.addr_o), 0);
        chk_w("reset_data", bus.data_o, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle("idle");

        // Two rows, continuous valid, start poked during DONE.
        make_stim(2, 0);
        run_block("two_rows", 2, 0, 1'b0, 1'b1);

        // Counting beats land in order inside the row.
        make_stim(1, 1);
        run_block("count", 1, 0, 1'b0, 1'b0);
        chk_w("count_row", wd_q[wd_q.size() - 1],
              {BEAT_W'(4), BEAT_W'(3), BEAT_W'(2), BEAT_W'(1)});

        // Toggling valid, start held high during the block.
        make_stim(1, 0);
        run_block("toggle", 1, 1, 1'b1, 1'b0);

        // Zero rows: done right away, no RAM access.
        stim.delete();
        run_block("zero", 0, 0, 1'b0, 1'b0);

        // Oversized request saturates to the full buffer.
        make_stim(32, 0);
        run_block("sat40", 40, 0, 1'b0, 1'b0);

        // Random valid pattern.
        make_stim(5, 0);
        run_block("rand5", 5, 2, 1'b0, 1'b0);

        // Reset after two beats of row 0.
        begin
            int wa0;
            make_stim(1, 0);
            wa0 = wa_q.size();
            @(posedge clk); #1;
            start_i = 1'b1; row_num_i = 6'd1;
            @(posedge clk); #1;
            start_i = 1'b0;
            bus.coeff_valid_i = 1'b1; bus.coeff_data_i = stim[0];
            @(posedge clk); #1;
            bus.coeff_data_i = stim[1];
            @(posedge clk); #1;
            rst = 1'b1; bus.coeff_data_i = stim[2];
            @(posedge clk); #1;
            rst = 1'b0; bus.coeff_data_i = stim[3];
            @(negedge clk);
            chk_idle("rst_mid");
            @(posedge clk); #1;
            bus.coeff_valid_i = 1'b0;
            @(negedge clk);
            chk_i("rst_mid_nowrite", wa_q.size() - wa0, 0);
        end
        make_stim(1, 0);
        run_block("after_rst", 1, 0, 1'b0, 1'b0);

`ifdef TQ_COEFF_PACK_NZ_EN
        make_stim(3, 2);
        run_block("nz", 3, 0, 1'b0, 1'b0);
        begin
            logic [31:0] exp_nz;
            exp_nz = '0;
            for (int r = 0; r < 3; r++) exp_nz[r] = |exp_row(r);
            chk_w("nz_model", ROW_W'(exp_nz), ROW_W'(32'h0000_0005));
            if (nzd_q.size() > 0) chk_w("nz_map", ROW_W'(nzd_q[nzd_q.size() - 1]), ROW_W'(exp_nz));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tq_coeff_packer.md
# tq_coeff_packer

Upstream write-side controller for the TQ 32x512 coefficient buffer. Accepts quantized coefficients from the quantizer as 128-bit beats (8 x 16-bit) over a valid/ready handshake. Packs every 4 beats into one 512-bit row and writes it into the single-port coefficient RAM at consecutive row addresses. Signals completion once the requested number of rows has been written.

## Interface
- COEFF_W, 16, coefficient width in bits
- BEAT_COEFFS, 8, coefficients per input beat (beat width 128)
- BEATS_PER_ROW, 4, beats packed into one 512-bit RAM row
- ADDR_W, 5, RAM row address width (32 rows)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start_i  in  1  one-cycle pulse; begins a block; honoured only in IDLE
- row_num_i  in  6  rows to write, sampled with start_i
- coeff_valid_i  in  1  beat valid
- coeff_data_i  in  128  beat; coefficient c at [16c+15:16c]
- coeff_ready_o  out  1  beat accepted when valid & ready
- busy_o  out  1  high whenever state != IDLE
- done_o  out  1  one-cycle pulse after the last row write
- cen_o  out  1  RAM chip enable, active-low
- oen_o  out  1  RAM output enable, active-low; held 1 (writer never reads)
- wen_o  out  1  RAM write enable, active-low
- addr_o  out  5  RAM row address
- data_o  out  512  RAM write data

## Operation
- FSM states: IDLE, FILL, WRITE, DONE.
- IDLE: start_i=1 latches row count, clears row counter and beat counter; row_num_i=0 -> DONE directly; row_num_i>32 saturates to 32; otherwise -> FILL.
- FILL: coeff_ready_o=1. Each accepted beat k (0..3) goes to row-buffer bits [128k+127:128k]; beat counter increments. Accepting beat 3 -> WRITE.
- WRITE: coeff_ready_o=0; cen_o=0, wen_o=0, addr_o=row counter, data_o=packed row, all for exactly one cycle. Next: row counter+1; if it equals row count -> DONE, else FILL with beat counter 0.
- DONE: done_o=1 for one cycle -> IDLE.
- Outside WRITE: cen_o=1, wen_o=1; addr_o, data_o hold last value.
- start_i outside IDLE is ignored, including in DONE.
- coeff_valid_i outside FILL is ignored (ready low); no beat is lost or duplicated.
- Reset in any state: IDLE, partial row discarded, counters cleared; no write is issued on the cycle after reset.

## Timing
- All outputs registered. Reset values: coeff_ready_o=0, busy_o=0, done_o=0, cen_o=1, oen_o=1, wen_o=1, addr_o=0, data_o=0.
- start_i at edge t -> coeff_ready_o high from cycle t+1.
- Write cycle is the cycle after the edge accepting beat 3; RAM captures on the following edge.
- Continuous valid: 5 cycles per row (4 accept + 1 write). N rows: first ready to done_o = 5N cycles.
- row_num_i=0: done_o is asserted 1 cycle after the start cycle, with no RAM access.

## Configuration
- TQ_COEFF_PACK_NZ_EN defined: adds output nz_map_o[31:0]. Bit r is set when row r contains any nonzero coefficient. Updated in the WRITE cycle and cleared at accepted start_i and at reset. Valid once done_o is asserted.
- Undefined: no nz_map_o port and no detection logic; all other behaviour identical.

## Structure
- Shared package tq_coeff_pkg holds:
  - constants COEFF_W, BEAT_COEFFS, BEATS_PER_ROW, ROW_W=512, ADDR_W=5, MAX_ROWS=32;
  - the state enum {IDLE, FILL, WRITE, DONE}.
- One sub-module, tq_coeff_nz_detect: combinational OR-reduction of a 512-bit row to a 1-bit nonzero flag. Instantiated only under TQ_COEFF_PACK_NZ_EN.

## Test plan
- Reset, then idle: all outputs at reset values; start_i with row_num_i=2 -> exactly 2 writes, addr 0 then 1, done_o at cycle 10 after the first ready cycle.
- Beats 0x..01, 0x..02, 0x..03, 0x..04 (128-bit each) -> data_o = {beat3,beat2,beat1,beat0} at addr 0 with cen_o=wen_o=0 for one cycle.
- valid toggled 1/0 every cycle, row_num_i=1 -> ready stays high in FILL; row written once all 4 beats arrive; no beat dropped.
- row_num_i=0 -> done_o one cycle after start, cen_o never low; row_num_i=40 -> 32 writes, addr 0..31, then done_o.
- rst after 2 beats of row 0 -> IDLE next cycle, no write; new start rewrites addr 0 from fresh beats.
- TQ_COEFF_PACK_NZ_EN, 3 rows with row 1 all zeros -> nz_map_o=32'h0000_0005 at done_o.
